gin_leak_scheduler: RTL and testbench
=====================================

Name: gin_leak_scheduler

Overview:
- Sequences the shared combinational inhibitory-conductance leak unit across every neuron once per timestep.
- Streams gin values out of the gin state RAM, routes each through the leak unit, and writes the decayed value back to the same address.
- Sits between the timestep controller (Start/Done) and the gin RAM. Sustains one neuron per clock and yields the RAM port to higher-priority requesters via Pause.

Parameters:
- INTEGER_WIDTH, 32, integer bits of the fixed-point gin format.
- DATA_WIDTH_FRAC, 32, fractional bits of the fixed-point gin format.
- DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC, full gin word width.
- DELTAT_WIDTH, 4, timestep width in fractional units.
- NEURON_WIDTH, 11, neuron address width.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  one-cycle pulse that begins a sweep.
- NeuronCount  in  NEURON_WIDTH  number of neurons to sweep, latched on Start.
- DeltaT  in  DELTAT_WIDTH  timestep, latched on Start.
- Taugin  in  INTEGER_WIDTH  time constant, latched on Start.
- Pause  in  1  external RAM requester active; suppress new reads.
- GinRdEn  out  1  gin RAM read enable.
- GinRdAddr  out  NEURON_WIDTH  gin RAM read address.
- GinRdData  in  DATA_WIDTH  read data, valid exactly 1 cycle after GinRdEn.
- LeakGin  out  DATA_WIDTH  operand to the leak unit.
- LeakDeltaT  out  DELTAT_WIDTH  latched DeltaT to the leak unit.
- LeakTaugin  out  INTEGER_WIDTH  latched Taugin to the leak unit.
- LeakGinOut  in  DATA_WIDTH  leak unit result, combinational from the operands.
- GinWrEn  out  1  gin RAM write enable.
- GinWrAddr  out  NEURON_WIDTH  write address.
- GinWrData  out  DATA_WIDTH  write data.
- Busy  out  1  sweep in progress.
- Done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset:
  - All outputs go to 0 on the clock edge where Reset is high. FSM goes to IDLE; pipeline valid bits, counters and latched configuration clear.
  - Reset mid-sweep aborts the sweep: no further reads or writes, and no Done pulse.
- FSM states:
  - IDLE: Start → latch NeuronCount, DeltaT and Taugin; go to SWEEP (or DONE if NeuronCount==0).
  - SWEEP: issue reads until NeuronCount reads are issued, then go to DRAIN.
  - DRAIN: wait until both pipeline stages are empty, then go to DONE.
  - DONE: Done=1 for exactly one cycle, Busy=0, return to IDLE.
  - Start while Busy is ignored.
- Pipeline, 3 stages, throughput 1 neuron per cycle:
  - S0 (SWEEP, Pause=0): GinRdEn=1, GinRdAddr=rd_ptr, rd_ptr increments. Addresses run 0..NeuronCount-1 with no wrap.
  - S1 (next cycle): LeakGin=GinRdData. At the clock edge, register LeakGinOut and the address into the S2 register.
  - S2: GinWrEn=1, with GinWrAddr/GinWrData from the S2 register. The write for address i appears 2 cycles after its read.
  - LeakGin, LeakDeltaT and LeakTaugin are held stable while S1 is invalid (no glitching requirement beyond that).
- Pause:
  - Pause sampled high in SWEEP → GinRdEn=0 that cycle and rd_ptr holds.
  - In-flight S1/S2 items complete normally; writes are not stalled.
  - Pause has no effect in IDLE, DRAIN or DONE.
- Timing:
  - With no Pause: Start in cycle 0; reads in cycles 1..N; writes in cycles 3..N+2; Done in cycle N+3.
  - Busy=1 in cycles 1..N+2.
  - Each Pause cycle during SWEEP delays Done by one cycle.
- Taugin==0 (latched): the leak result is invalid, so S1 registers GinRdData unchanged. The sweep still writes every address and asserts Done.
- No read-after-write hazard: each address is read once and written once, and writes trail reads.

Test Plan:
- NeuronCount=4, DeltaT=1, Taugin=8, RAM gin=1.0 (0x1_00000000) everywhere, no Pause → reads at cycles 1-4, writes at 3-6 with the addresses in order, each written value equals LeakGinOut for 1.0, Done at cycle 7, Busy high for cycles 1-6.
- NeuronCount=0 → no GinRdEn/GinWrEn, Done at cycle 1.
- NeuronCount=6, Pause high in cycles 2-3 → reads of addresses 1..5 shifted by 2 cycles, all 6 writes correct, Done at cycle 11.
- Reset asserted in cycle 3 of a 10-neuron sweep → from the next cycle on: GinWrEn=0, Busy=0, no Done pulse; a later Start performs a full sweep correctly.
- Taugin=0, NeuronCount=3 with gin values 5, -2, 7 → written values are 5, -2, 7 unchanged, Done asserted.
- Start re-pulsed mid-sweep with a different NeuronCount → ignored; the original count completes.

Source files
------------

// File: rtl/gin_leak_scheduler.sv
// gin_leak_scheduler
//   Walks every neuron's inhibitory conductance (gin) once per timestep:
//   read gin from the state RAM, pass it through the shared combinational
//   leak unit, and write the decayed value back to the same address.
//   Sustains one neuron per clock; a high Pause yields the RAM read port.
//
// Ports
//   Clock_i, Reset_i          clock (rising edge), synchronous active-high reset
//   Start_i                   one-cycle pulse that begins a sweep (ignored while busy)
//   NeuronCount_i, DeltaT_i,
//   Taugin_i                  sweep configuration, latched on Start_i
//   Pause_i                   another RAM requester is active; hold off new reads
//   GinRdEn_o, GinRdAddr_o    gin RAM read request
//   GinRdData_i               read data, valid one cycle after GinRdEn_o
//   LeakGin_o, LeakDeltaT_o,
//   LeakTaugin_o              operands to the leak unit
//   LeakGinOut_i              leak unit result (combinational from the operands)
//   GinWrEn_o, GinWrAddr_o,
//   GinWrData_o               gin RAM write-back
//   Busy_o, Done_o            sweep in progress / one-cycle completion pulse

module gin_leak_scheduler #(
    parameter int INTEGER_WIDTH   = 32,
    parameter int DATA_WIDTH_FRAC = 32,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int DELTAT_WIDTH    = 4,
    parameter int NEURON_WIDTH    = 11
) (
    input  logic                     Clock_i,
    input  logic                     Reset_i,
    input  logic                     Start_i,
    input  logic [NEURON_WIDTH-1:0]  NeuronCount_i,
    input  logic [DELTAT_WIDTH-1:0]  DeltaT_i,
    input  logic [INTEGER_WIDTH-1:0] Taugin_i,
    input  logic                     Pause_i,
    output logic                     GinRdEn_o,
    output logic [NEURON_WIDTH-1:0]  GinRdAddr_o,
    input  logic [DATA_WIDTH-1:0]    GinRdData_i,
    output logic [DATA_WIDTH-1:0]    LeakGin_o,
    output logic [DELTAT_WIDTH-1:0]  LeakDeltaT_o,
    output logic [INTEGER_WIDTH-1:0] LeakTaugin_o,
    input  logic [DATA_WIDTH-1:0]    LeakGinOut_i,
    output logic                     GinWrEn_o,
    output logic [NEURON_WIDTH-1:0]  GinWrAddr_o,
    output logic [DATA_WIDTH-1:0]    GinWrData_o,
    output logic                     Busy_o,
    output logic                     Done_o
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;

    state_e                   state_q;
    logic [NEURON_WIDTH-1:0]  rd_ptr_q;
    logic [NEURON_WIDTH-1:0]  cnt_q;
    logic [DELTAT_WIDTH-1:0]  dt_q;
    logic [INTEGER_WIDTH-1:0] tau_q;
    logic [2:1]               vld_pipe_q;   // [1] = S1 valid, [2] = S2 valid
    logic [NEURON_WIDTH-1:0]  s1_addr_q;
    logic [NEURON_WIDTH-1:0]  s2_addr_q;
    logic [DATA_WIDTH-1:0]    s2_data_q;
    logic [DATA_WIDTH-1:0]    gin_hold_q;   // last S1 operand, keeps LeakGin steady when idle
    logic                     busy_q;
    logic                     done_q;

    logic rd_en;
    logic last_rd;

    // Pause acts in the same cycle it is seen, so the read strobe is decoded
    // from state plus Pause rather than registered.
    assign rd_en   = (state_q == SWEEP) && !Pause_i;
    assign last_rd = (rd_ptr_q == cnt_q - NEURON_WIDTH'(1));

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            dt_q       <= '0;
            tau_q      <= '0;
            vld_pipe_q <= '0;
            s1_addr_q  <= '0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
            gin_hold_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[1], rd_en};
            if (rd_en) begin
                s1_addr_q <= rd_ptr_q;
            end
            if (vld_pipe_q[1]) begin
                s2_addr_q  <= s1_addr_q;
                // A zero time constant makes the leak result meaningless;
                // write the value back untouched instead.
                s2_data_q  <= (tau_q == '0) ? GinRdData_i : LeakGinOut_i;
                gin_hold_q <= GinRdData_i;
            end

            case (state_q)
                IDLE: begin
                    if (Start_i) begin
                        cnt_q    <= NeuronCount_i;
                        dt_q     <= DeltaT_i;
                        tau_q    <= Taugin_i;
                        rd_ptr_q <= '0;
                        if (NeuronCount_i == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SWEEP;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    if (rd_en) begin
                        rd_ptr_q <= rd_ptr_q + NEURON_WIDTH'(1);
                        if (last_rd) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Once S1 is empty the S2 write retires this cycle, so
                    // Done lands the cycle after the final write.
                    if (!vld_pipe_q[1]) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign GinRdEn_o    = rd_en;
    assign GinRdAddr_o  = rd_ptr_q;
    assign LeakGin_o    = vld_pipe_q[1] ? GinRdData_i : gin_hold_q;
    assign LeakDeltaT_o = dt_q;
    assign LeakTaugin_o = tau_q;
    assign GinWrEn_o    = vld_pipe_q[2];
    assign GinWrAddr_o  = s2_addr_q;
    assign GinWrData_o  = s2_data_q;
    assign Busy_o       = busy_q;
    assign Done_o       = done_q;

endmodule

// File: tb/tb_gin_leak_scheduler.sv
module tb_gin_leak_scheduler;

    logic        Clock = 1'b0;
    logic        Reset, Start, Pause;
    logic [10:0] NeuronCount;
    logic [3:0]  DeltaT;
    logic [31:0] Taugin;
    logic        GinRdEn;
    logic [10:0] GinRdAddr;
    logic [63:0] GinRdData;
    logic [63:0] LeakGin;
    logic [3:0]  LeakDeltaT;
    logic [31:0] LeakTaugin;
    logic [63:0] LeakGinOut;
    logic        GinWrEn;
    logic [10:0] GinWrAddr;
    logic [63:0] GinWrData;
    logic        Busy, Done;

    gin_leak_scheduler dut (
        .Clock_i(Clock), .Reset_i(Reset), .Start_i(Start),
        .NeuronCount_i(NeuronCount), .DeltaT_i(DeltaT), .Taugin_i(Taugin),
        .Pause_i(Pause), .GinRdEn_o(GinRdEn), .GinRdAddr_o(GinRdAddr),
        .GinRdData_i(GinRdData), .LeakGin_o(LeakGin), .LeakDeltaT_o(LeakDeltaT),
        .LeakTaugin_o(LeakTaugin), .LeakGinOut_i(LeakGinOut), .GinWrEn_o(GinWrEn),
        .GinWrAddr_o(GinWrAddr), .GinWrData_o(GinWrData), .Busy_o(Busy), .Done_o(Done)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    int cnt = 0;
    int t0 = 0;
    logic [63:0] mem [0:15];

    always @(posedge Clock) cnt <= cnt + 1;

    // Gin RAM read port: one-cycle latency.
    always @(posedge Clock) if (GinRdEn) GinRdData <= mem[GinRdAddr[3:0]];

    // Reference leak unit: g - (g/16)*dt/tau.
    function automatic logic [63:0] leak(input logic [63:0] g, input logic [3:0] dt, input logic [31:0] tau);
        logic signed [63:0] s, d;
        s = g;
        if (tau == 0) return 64'hDEAD_BEEF_0BAD_F00D;
        d = (s >>> 4) * $signed({60'd0, dt});
        d = d / $signed({32'd0, tau});
        return s - d;
    endfunction

    always_comb LeakGinOut = leak(LeakGin, LeakDeltaT, LeakTaugin);

    typedef struct {
        int          addr;
        logic [63:0] data;
        int          cyc;
    } ev_t;
    ev_t rd_q[$];
    ev_t wr_q[$];
    ev_t re, we;

    // Scoreboard: every read/write the DUT makes must match the next expected one.
    always @(negedge Clock) begin
        if (GinRdEn) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got addr=%0d cyc=%0d want none", GinRdAddr, cnt - t0);
            end else begin
                re = rd_q.pop_front();
                if (GinRdAddr !== 11'(re.addr) || (cnt - t0) != re.cyc) begin
                    errors++;
                    $display("FAIL rd got addr=%0d cyc=%0d want addr=%0d cyc=%0d", GinRdAddr, cnt - t0, re.addr, re.cyc);
                end
            end
        end
        if (GinWrEn) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected got addr=%0d data=%h cyc=%0d want none", GinWrAddr, GinWrData, cnt - t0);
            end else begin
                we = wr_q.pop_front();
                if (GinWrAddr !== 11'(we.addr) || GinWrData !== we.data || (cnt - t0) != we.cyc) begin
                    errors++;
                    $display("FAIL wr got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                             GinWrAddr, GinWrData, cnt - t0, we.addr, we.data, we.cyc);
                end
            end
        end
    end

    task automatic push_exp(input int a, input int rc, input logic [63:0] d);
        ev_t e;
        e.addr = a; e.data = 64'd0; e.cyc = rc;
        rd_q.push_back(e);
        e.data = d; e.cyc = rc + 2;
        wr_q.push_back(e);
    endtask

    // Runs one sweep; cycle 0 is the Start cycle. rs re-pulses Start with a
    // different count/Taugin, rst asserts Reset in that cycle.
    task automatic drive_sweep(input int n, input int dt, input int tau, input int p_lo, input int p_hi,
                               input int rs, input int rst, input int maxc,
                               output int dc, output int dn, output int bf, output int bl, output int bc);
        dc = -1; dn = 0; bf = -1; bl = -1; bc = 0;
        @(posedge Clock); #1;
        t0 = cnt;
        for (int rel = 0; rel < maxc; rel++) begin
            if (rel > 0) begin @(posedge Clock); #1; end
            Start       = (rel == 0) || (rel == rs);
            NeuronCount = (rel == 0) ? 11'(n) : 11'(n + 5);
            Taugin      = (rel == 0) ? 32'(tau) : 32'(tau + 3);
            DeltaT      = 4'(dt);
            Pause       = (rel >= p_lo) && (rel <= p_hi);
            Reset       = (rel == rst);
            @(negedge Clock);
            if (Busy) begin
                if (bf < 0) bf = rel;
                bl = rel;
                bc++;
            end
            if (Done) begin
                dn++;
                if (dc < 0) dc = rel;
            end
            if (dc >= 0 && rel > dc) break;
        end
        @(posedge Clock); #1;
        Start = 0; Pause = 0; Reset = 0;
    endtask

    task automatic test_reset;
        Reset = 1; Start = 0; Pause = 0; NeuronCount = 0; DeltaT = 0; Taugin = 0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        checks++; if (GinRdEn !== 1'b0 || GinWrEn !== 1'b0) begin errors++; $display("FAIL reset_en got rd=%b wr=%b want 0 0", GinRdEn, GinWrEn); end
        checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL reset_status got busy=%b done=%b want 0 0", Busy, Done); end
        checks++; if (LeakGin !== 64'd0 || LeakDeltaT !== 4'd0 || LeakTaugin !== 32'd0) begin errors++; $display("FAIL reset_leak got %h %h %h want 0", LeakGin, LeakDeltaT, LeakTaugin); end
        checks++; if (GinRdAddr !== 11'd0 || GinWrAddr !== 11'd0 || GinWrData !== 64'd0) begin errors++; $display("FAIL reset_addr got %h %h %h want 0", GinRdAddr, GinWrAddr, GinWrData); end
        #1 Reset = 0;
    endtask

    task automatic test_basic(input int n, input string nm);
        int dc, dn, bf, bl, bc;
        for (int i = 0; i < 16; i++) mem[i] = 64'h1_0000_0000;
        for (int i = 0; i < n; i++) push_exp(i, i + 1, leak(mem[i], 4'd1, 32'd8));
        drive_sweep(n, 1, 8, -1, -1, -1, -1, 60, dc, dn, bf, bl, bc);
        checks++; if (dc != n + 3 || dn != 1) begin errors++; $display("FAIL %s_done got cyc=%0d pulses=%0d want cyc=%0d pulses=1", nm, dc, dn, n + 3); end
        checks++; if (bf != 1 || bl != n + 2 || bc != n + 2) begin errors++; $display("FAIL %s_busy got %0d..%0d (%0d) want 1..%0d", nm, bf, bl, bc, n + 2); end
        checks++; if (LeakDeltaT !== 4'd1 || LeakTaugin !== 32'd8) begin errors++; $display("FAIL %s_cfg got dt=%0d tau=%0d want 1 8", nm, LeakDeltaT, LeakTaugin); end
        checks++; if (rd_q.size() != 0 || wr_q.size() != 0) begin errors++; $display("FAIL %s_left got rd=%0d wr=%0d want 0 0", nm, rd_q.size(), wr_q.size()); end
        rd_q.delete(); wr_q.delete();
    endtask

    task automatic test_zero;
        int dc, dn, bf, bl, bc;
        drive_sweep(0, 1, 8, -1, -1, -1, -1, 20, dc, dn, bf, bl, bc);
        checks++; if (dc != 1 || dn != 1) begin errors++; $display("FAIL zero_done got cyc=%0d pulses=%0d want 1 1", dc, dn); end
        checks++; if (bc != 0) begin errors++; $display("FAIL zero_busy got %0d busy cycles want 0", bc); end
    endtask

    task automatic test_pause;
        int dc, dn, bf, bl, bc;
        for (int i = 0; i < 16; i++) mem[i] = 64'((i + 1)) << 32 | 64'(i * 32'h1234_5678);
        for (int i = 0; i < 6; i++) push_exp(i, (i == 0) ? 1 : i + 3, leak(mem[i], 4'd3, 32'd5));
        drive_sweep(6, 3, 5, 2, 3, -1, -1, 60, dc, dn, bf, bl, bc);
        checks++; if (dc != 11 || dn != 1) begin errors++; $display("FAIL pause_done got cyc=%0d pulses=%0d want 11 1", dc, dn); end
        checks++; if (bf != 1 || bl != 10 || bc != 10) begin errors++; $display("FAIL pause_busy got %0d..%0d (%0d) want 1..10", bf, bl, bc); end
        checks++; if (rd_q.size() != 0 || wr_q.size() != 0) begin errors++; $display("FAIL pause_left got rd=%0d wr=%0d want 0 0", rd_q.size(), wr_q.size()); end
        rd_q.delete(); wr_q.delete();
    endtask

    task automatic test_reset_mid;
        int dc, dn, bf, bl, bc;
        for (int i = 0; i < 16; i++) mem[i] = 64'h1_0000_0000;
        // Reads in cycles 1..3 (cycle 3 still reads), only address 0 written.
        for (int i = 0; i < 3; i++) begin
            re.addr = i; re.data = 0; re.cyc = i + 1;
            rd_q.push_back(re);
        end
        we.addr = 0; we.data = leak(mem[0], 4'd1, 32'd8); we.cyc = 3;
        wr_q.push_back(we);
        drive_sweep(10, 1, 8, -1, -1, -1, 3, 20, dc, dn, bf, bl, bc);
        checks++; if (dn != 0) begin errors++; $display("FAIL rstmid_done got %0d pulses want 0", dn); end
        checks++; if (bl != 3) begin errors++; $display("FAIL rstmid_busy got last busy cycle %0d want 3", bl); end
        checks++; if (rd_q.size() != 0 || wr_q.size() != 0) begin errors++; $display("FAIL rstmid_left got rd=%0d wr=%0d want 0 0", rd_q.size(), wr_q.size()); end
        rd_q.delete(); wr_q.delete();
    endtask

    task automatic test_tau0;
        int dc, dn, bf, bl, bc;
        mem[0] = 64'h0000_0005_0000_0000;
        mem[1] = 64'hFFFF_FFFE_0000_0000;
        mem[2] = 64'h0000_0007_0000_0000;
        for (int i = 0; i < 3; i++) push_exp(i, i + 1, mem[i]);
        drive_sweep(3, 2, 0, -1, -1, -1, -1, 40, dc, dn, bf, bl, bc);
        checks++; if (dc != 6 || dn != 1) begin errors++; $display("FAIL tau0_done got cyc=%0d pulses=%0d want 6 1", dc, dn); end
        checks++; if (rd_q.size() != 0 || wr_q.size() != 0) begin errors++; $display("FAIL tau0_left got rd=%0d wr=%0d want 0 0", rd_q.size(), wr_q.size()); end
        rd_q.delete(); wr_q.delete();
    endtask

    task automatic test_restart;
        int dc, dn, bf, bl, bc;
        for (int i = 0; i < 16; i++) mem[i] = 64'h0000_0003_8000_0000 + 64'(i);
        for (int i = 0; i < 4; i++) push_exp(i, i + 1, leak(mem[i], 4'd1, 32'd8));
        drive_sweep(4, 1, 8, -1, -1, 2, -1, 40, dc, dn, bf, bl, bc);
        checks++; if (dc != 7 || dn != 1) begin errors++; $display("FAIL restart_done got cyc=%0d pulses=%0d want 7 1", dc, dn); end
        checks++; if (LeakTaugin !== 32'd8) begin errors++; $display("FAIL restart_cfg got tau=%0d want 8", LeakTaugin); end
        checks++; if (rd_q.size() != 0 || wr_q.size() != 0) begin errors++; $display("FAIL restart_left got rd=%0d wr=%0d want 0 0", rd_q.size(), wr_q.size()); end
        rd_q.delete(); wr_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic(4, "basic");
        test_zero();
        test_pause();
        test_reset_mid();
        test_basic(5, "after_rst");
        test_tau0();
        test_restart();
        repeat (3) @(posedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
